// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] SAMPLE_T0  = 4'd7;
    localparam logic [3:0] SAMPLE_T1  = 4'd8;
    localparam logic [3:0] SAMPLE_T2  = 4'd9;
    localparam logic [3:0] TICK_LAST  = 4'(OVERSAMPLE - 1);
    localparam int         DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_os_if.sv
// Byte-side handshake of the receiver: valid/ready data plus status pulses.
interface uart_rx_os_if;

    logic [7:0] dout;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    modport master (output dout, output valid, output frame_err, output overrun, input ready);
    modport slave  (input dout, input valid, input frame_err, input overrun, output ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling prescaler: one-clk tick every clk_freq/(baud_rate*OVERSAMPLE) clocks.
module uart_baud_tick #(
    parameter int clk_freq   = 1_000_000,
    parameter int baud_rate  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int             DIV  = clk_freq / (baud_rate * OVERSAMPLE);
    localparam int             W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampling 8N1 UART receiver with 3-sample majority vote and a valid/ready byte output.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int clk_freq  = 1_000_000,
    parameter int baud_rate = 9600
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    uart_rx_os_if.master  bus
);

    logic       s1_q, s2_q, rxs;
    rx_state_t  state_q;
    logic [3:0] tidx_q;
    logic [2:0] bit_q;
    logic [7:0] shift_q, dout_q;
    logic       valid_q, ferr_q, ovr_q;
    logic       smp0_q, smp1_q;
    logic       tick, maj, clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= rx;
            s2_q <= s1_q;
        end
    end
    assign rxs = s2_q;

    // Prescaler only runs while a frame is being timed.
    assign clr = (state_q == IDLE) || (state_q == WAIT_HIGH);

    uart_baud_tick #(
        .clk_freq  (clk_freq),
        .baud_rate (baud_rate),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .tick_o(tick)
    );

    // Third sample is the live line value at the deciding tick.
    assign maj = (smp0_q & smp1_q) | (smp0_q & rxs) | (smp1_q & rxs);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tidx_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            smp0_q  <= 1'b0;
            smp1_q  <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            if (valid_q && bus.ready) valid_q <= 1'b0;
            if (tick) begin
                tidx_q <= tidx_q + 1'b1;
                if (tidx_q == SAMPLE_T0) smp0_q <= rxs;
                if (tidx_q == SAMPLE_T1) smp1_q <= rxs;
            end
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        tidx_q  <= '0;
                        bit_q   <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick && tidx_q == SAMPLE_T2 && maj) state_q <= IDLE;
                    else if (tick && tidx_q == TICK_LAST)   state_q <= DATA;
                end
                DATA: begin
                    if (tick && tidx_q == SAMPLE_T2) shift_q <= {maj, shift_q[7:1]};
                    if (tick && tidx_q == TICK_LAST) begin
                        if (bit_q == 3'(DATA_BITS - 1)) state_q <= STOP;
                        else                            bit_q   <= bit_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick && tidx_q == SAMPLE_T2) begin
                        if (!maj) begin
                            ferr_q  <= 1'b1;
                            state_q <= WAIT_HIGH;
                        end else begin
                            // A byte being consumed this clock frees the slot for the new one.
                            if (!valid_q || bus.ready) begin
                                dout_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                            state_q <= IDLE;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dout      = dout_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at default clock/baud (DIV=6, 96 clk per bit).
module tb_uart_rx_os;
    import uart_pkg::*;

    localparam int DIV = 6;
    localparam int BIT = DIV * 16;
    localparam int LAT = 154 * DIV + 3;

    logic clk, rst, rx;
    uart_rx_os_if bus();

    uart_rx_os #(.clk_freq(1_000_000), .baud_rate(9600)) dut (
        .clk(clk), .rst(rst), .rx(rx), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int fall_cyc = 0, vrise_cyc = -1;
    int ferr_cnt = 0, ovr_cnt = 0;
    logic valid_prev = 1'b0;
    int n_checks = 0, n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.frame_err) ferr_cnt++;
        if (bus.overrun) ovr_cnt++;
        if (bus.valid && !valid_prev) vrise_cyc = cyc;
        valid_prev = bus.valid;
    end

    // Drives start, 8 data bits LSB first, and stop; optionally flips one of the
    // three sample points per data bit (sampled at in-bit offsets 48/54/60).
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit noise, input int max_it);
        logic v;
        int it;
        it = 0;
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < BIT; i++) begin
                if (it == max_it) return;
                @(posedge clk); #1;
                if (n == 0 && i == 0) fall_cyc = cyc;
                v = (n == 0) ? 1'b0 : (n == 9) ? stop : b[n-1];
                rx = (noise && n >= 1 && n <= 8 && i == 48 + 6 * ((n - 1) % 3)) ? ~v : v;
                it++;
            end
        end
    endtask

    task automatic pulse_ready();
        @(posedge clk); #1 bus.ready = 1'b1;
        @(posedge clk); #1 bus.ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; rx = 1'b1; bus.ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", bus.dout); end
        n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
        n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", bus.frame_err); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", bus.overrun); end
        @(posedge clk); #1 rst = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_basic();
        int f0, o0;
        f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, 10 * BIT);
        @(negedge clk);
        n_checks++; if (vrise_cyc - fall_cyc !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", vrise_cyc - fall_cyc, LAT); end
        n_checks++; if (bus.dout !== 8'hA5) begin n_fail++; $display("FAIL basic_dout: got %h expected a5", bus.dout); end
        repeat (200) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_held: got %b expected 1", bus.valid); end
        pulse_ready();
        @(negedge clk);
        n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_clear: got %b expected 0", bus.valid); end
        n_checks++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL basic_ferr: got %0d pulses expected 0", ferr_cnt - f0); end
        n_checks++; if (ovr_cnt - o0 !== 0) begin n_fail++; $display("FAIL basic_ovr: got %0d pulses expected 0", ovr_cnt - o0); end
    endtask

    task automatic test_glitch();
        int f0;
        f0 = ferr_cnt;
        @(posedge clk); #1 rx = 1'b0;
        repeat (12) @(posedge clk);
        #1 rx = 1'b1;
        repeat (300) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b expected 0", bus.valid); end
        n_checks++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d pulses expected 0", ferr_cnt - f0); end
        n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL glitch_state: got %0d expected %0d", dut.state_q, IDLE); end
    endtask

    task automatic test_frame_err();
        int f0;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 10 * BIT);
        repeat (300) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d pulses expected 1", ferr_cnt - f0); end
        n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL ferr_valid: got %b expected 0", bus.valid); end
        @(posedge clk); #1 rx = 1'b1;
        repeat (1200) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL ferr_no_new_frame: got %b expected 0", bus.valid); end
        n_checks++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_once: got %0d pulses expected 1", ferr_cnt - f0); end
        send_frame(8'h81, 1'b1, 1'b0, 10 * BIT);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.dout !== 8'h81) begin n_fail++; $display("FAIL ferr_next_dout: got %h expected 81", bus.dout); end
        n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL ferr_next_valid: got %b expected 1", bus.valid); end
        pulse_ready();
    endtask

    task automatic test_back_to_back();
        int o0;
        o0 = ovr_cnt;
        send_frame(8'h3C, 1'b1, 1'b0, 10 * BIT);
        send_frame(8'hC3, 1'b1, 1'b0, 10 * BIT);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.dout !== 8'h3C) begin n_fail++; $display("FAIL b2b_dout: got %h expected 3c", bus.dout); end
        n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b expected 1", bus.valid); end
        n_checks++; if (ovr_cnt - o0 !== 1) begin n_fail++; $display("FAIL b2b_overrun: got %0d pulses expected 1", ovr_cnt - o0); end
        pulse_ready();
    endtask

    task automatic test_noise();
        send_frame(8'h55, 1'b1, 1'b1, 10 * BIT);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.dout !== 8'h55) begin n_fail++; $display("FAIL noise_dout: got %h expected 55", bus.dout); end
        n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL noise_valid: got %b expected 1", bus.valid); end
    endtask

    task automatic test_reset_mid();
        // valid=1 / dout=55 left over from the noise frame must be wiped by reset
        send_frame(8'hFF, 1'b1, 1'b0, 5 * BIT + 30);
        @(posedge clk); #1 rst = 1'b0; rx = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.dout !== 8'h00) begin n_fail++; $display("FAIL rstmid_dout: got %h expected 00", bus.dout); end
        n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", bus.valid); end
        n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d expected %0d", dut.state_q, IDLE); end
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (200) @(posedge clk);
        send_frame(8'h0F, 1'b1, 1'b0, 10 * BIT);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.dout !== 8'h0F) begin n_fail++; $display("FAIL rstmid_next_dout: got %h expected 0f", bus.dout); end
        n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_next_valid: got %b expected 1", bus.valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_noise();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
